// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// Opcodes, the NOP word and the fetch FSM encoding.
package mips_pkg;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] JUMP_A = 6'h02;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2B;
  localparam logic [5:0] JUMP   = JUMP_A;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus.
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if;

  logic        o_imemReq;
  logic [31:0] o_imemAddr;
  logic        i_imemAck;
  logic [31:0] i_imemData;

  modport master (
    output o_imemReq,
    output o_imemAddr,
    input  i_imemAck,
    input  i_imemData
  );

  modport slave (
    input  o_imemReq,
    input  o_imemAddr,
    output i_imemAck,
    output i_imemData
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4, valid.
// Flush dominates load.
module if_id_reg #(
  parameter logic [31:0] NOP_VAL = mips_pkg::NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q <= NOP_VAL;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP_VAL;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: PC, imem req/ack, skid, IF/ID.
// Redirect beats stall; one request outstanding at most.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_stall,
  input  logic               i_redirect,
  input  logic [31:0]        i_redirectPc,
  fetch_stage_if.master      bus,
  output logic [31:0]        o_instr,
  output logic [5:0]         o_opcode,
  output logic [31:0]        o_pcPlus4,
  output logic               o_valid
);

  import mips_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  skid_q, skid_d;
  logic         started_q;

  logic         req;
  logic         ack;
  logic         load;
  logic         flush;
  logic [31:0]  ld_instr;
  logic [31:0]  next_addr;
  logic [31:0]  tgt;

  assign next_addr = pc_plus4(req_addr_q);
  assign tgt       = i_redirectPc & ~32'h3;

  // No request on the reset-release cycle; HOLD parks the bus.
  assign req            = started_q && (state_q != ST_HOLD);
  assign ack            = bus.i_imemAck && req;
  assign bus.o_imemReq  = req;
  assign bus.o_imemAddr = req_addr_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      skid_q     <= '0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      skid_q     <= skid_d;
      started_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    skid_d     = skid_q;
    load       = 1'b0;
    flush      = 1'b0;
    ld_instr   = bus.i_imemData;
    if (i_redirect) begin
      pc_d  = tgt;
      flush = 1'b1;
      unique case (state_q)
        ST_FETCH: begin
          if (ack) req_addr_d = tgt;
          else     state_d    = ST_DISCARD;
        end
        ST_HOLD: begin
          req_addr_d = tgt;
          state_d    = ST_FETCH;
        end
        default: ;
      endcase
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (ack && !i_stall) begin
            load       = 1'b1;
            pc_d       = next_addr;
            req_addr_d = next_addr;
          end else if (ack) begin
            skid_d  = bus.i_imemData;
            state_d = ST_HOLD;
          end else if (!i_stall) begin
            flush = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!i_stall) begin
            load       = 1'b1;
            ld_instr   = skid_q;
            pc_d       = next_addr;
            req_addr_d = next_addr;
            state_d    = ST_FETCH;
          end
        end
        ST_DISCARD: begin
          // Orphaned word arrives; resume at the redirected PC.
          if (ack) begin
            req_addr_d = pc_q;
            state_d    = ST_FETCH;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  if_id_reg #(
    .NOP_VAL (NOP_INSTR)
  ) u_if_id (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .load_i  (load),
    .flush_i (flush),
    .instr_i (ld_instr),
    .pc4_i   (next_addr),
    .instr_o (o_instr),
    .pc4_o   (o_pcPlus4),
    .valid_o (o_valid)
  );

  assign o_opcode = o_instr[31:26];

endmodule
